// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_arb_pkg;

  // Width of the DMA starvation counter. It must hold STARVE_LIMIT, which is at most 15.
  localparam int STARVE_W = 4;

  // The requester that drives the memory port in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating counter of consecutive DMA cycles that the CPU won.
// Latency: the count updates at the clock edge, and o_at_limit is combinational from the count.
// Backpressure: none; i_clr takes priority over i_inc.
//
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_inc            the DMA was denied this cycle
//   i_clr            the DMA was granted, or nothing is waiting
//   i_limit          saturation value
//   o_at_limit       the count has reached i_limit
module dmem_starve_ctr
  import dmem_arb_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  input  logic [STARVE_W-1:0] i_limit,
  output logic                o_at_limit
);

  logic [STARVE_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_at_limit = (r_cnt == i_limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA port.
// Latency: the CPU path is zero cycles; DMA read data returns 1 cycle after dma_gnt.
// Backpressure: the CPU has fixed priority and stalls for at most 1 cycle per DMA grant.
//   After STARVE_LIMIT denied cycles, the DMA is forced through for one cycle.
//
// Ports:
//   i_clk, i_rst_n                      clock and asynchronous active-low reset
//   i_cpu_*  / o_cpu_rdata, o_cpu_stall  MEM stage request and response
//   i_dma_*  / o_dma_gnt, o_dma_rdata, o_dma_rvalid  DMA request and registered read return
//   o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata   memory port (read is combinational)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_stall,
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic                  o_dma_gnt,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic                  o_dma_rvalid,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  owner_e w_owner;
  logic   w_at_limit;
  logic   w_dma_gnt;

  logic [DATA_WIDTH-1:0] r_dma_rdata;
  logic                  r_dma_rvalid;

  // A forced grant beats the CPU. Otherwise the DMA only gets idle CPU cycles.
  always_comb begin
    w_owner = OWN_NONE;
    if (i_dma_req && (w_at_limit || !i_cpu_req)) begin
      w_owner = OWN_DMA;
    end else if (i_cpu_req) begin
      w_owner = OWN_CPU;
    end
  end

  // Qualify with reset so that nothing is written to memory while rst_n is low.
  assign w_dma_gnt = i_rst_n && (w_owner == OWN_DMA);

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = i_cpu_addr;
    o_mem_wdata = i_cpu_wdata;
    if (w_owner == OWN_DMA) begin
      o_mem_we    = i_dma_we;
      o_mem_addr  = i_dma_addr;
      o_mem_wdata = i_dma_wdata;
    end else if (w_owner == OWN_CPU) begin
      o_mem_we = i_cpu_we;
    end
    if (!i_rst_n) begin
      o_mem_we = 1'b0;
    end
  end

  assign o_dma_gnt   = w_dma_gnt;
  assign o_cpu_stall = i_rst_n && i_cpu_req && (w_owner == OWN_DMA);
  assign o_cpu_rdata = i_mem_rdata;

  dmem_starve_ctr u_starve (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (i_dma_req && (w_owner == OWN_CPU)),
    .i_clr      (w_dma_gnt || !i_dma_req),
    .i_limit    (LIMIT),
    .o_at_limit (w_at_limit)
  );

  // Capture the memory's combinational read data at the end of a DMA read grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else if (w_dma_gnt && !i_dma_we) begin
      r_dma_rdata  <= i_mem_rdata;
      r_dma_rvalid <= 1'b1;
    end else begin
      r_dma_rvalid <= 1'b0;
    end
  end

  assign o_dma_rdata  = r_dma_rdata;
  assign o_dma_rvalid = r_dma_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr), .i_dma_wdata(dma_wdata),
    .o_dma_gnt(dma_gnt), .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory: combinational read, write at the clock edge.
  logic [31:0] mem [0:63];
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        gnt;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic        chk_rd;
    logic [31:0] rd;
  } ctl_t;

  ctl_t        q_ctl[$];
  logic [31:0] q_dma[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the cycle's control outputs with the queued expectation,
  // and match every dma_rvalid pulse against the queued read data.
  always @(negedge clk) begin
    ctl_t e;
    if (q_ctl.size() > 0) begin
      e = q_ctl.pop_front();
      chk("dma_gnt",   {31'd0, dma_gnt},   {31'd0, e.gnt});
      chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, e.stall});
      chk("mem_we",    {31'd0, mem_we},    {31'd0, e.we});
      chk("mem_addr",  mem_addr, e.addr);
      if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rd);
    end
    if (dma_rvalid) begin
      if (q_dma.size() == 0) chk("dma_rvalid_unexpected", 32'd1, 32'd0);
      else chk("dma_rdata", dma_rdata, q_dma.pop_front());
    end
  end

  // One stimulus cycle. The arguments are the inputs, the hand-computed grant, and the
  // expected read data (a CPU load, or a DMA read when the DMA is granted).
  task automatic cyc(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                     input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                     input logic eg, input logic [31:0] rexp);
    ctl_t e;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    e.gnt    = eg;
    e.stall  = cr && eg;
    e.we     = eg ? dw : (cr ? cw : 1'b0);
    e.addr   = eg ? da : ca;
    e.chk_rd = cr && !cw && !eg;
    e.rd     = rexp;
    q_ctl.push_back(e);
    if (eg && !dw) q_dma.push_back(rexp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    // The memory outputs must stay quiet in reset, even with both sides requesting.
    rst_n = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h1;
    dma_req = 1; dma_we = 1; dma_addr = 32'h48; dma_wdata = 32'h2;
    #3;
    chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst_dma_gnt",    {31'd0, dma_gnt},    32'd0);
    chk("rst_cpu_stall",  {31'd0, cpu_stall},  32'd0);
    chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("rst_dma_rdata",  dma_rdata,           32'd0);
    chk("rst_mem_addr",   mem_addr,            32'h44);
    cpu_req = 0; dma_req = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // CPU store followed by a load of the same address.
    cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    cyc(1, 0, 32'h10, 32'h0,        0, 0, 32'h0, 32'h0, 0, 32'hDEADBEEF);

    // DMA alone: a write, then a read of the same word.
    cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678, 1, 32'h0);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0,        1, 32'h12345678);
    idle();

    // Reset in the middle of a DMA read grant: the return pulse is lost.
    cpu_req = 0; dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    #2;
    rst_n = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
    #1;
    chk("midrst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("midrst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("midrst_dma_gnt",   {31'd0, dma_gnt},   32'd0);
    @(posedge clk); #1;
    chk("midrst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    chk("midrst_dma_rdata",  dma_rdata,           32'd0);
    cpu_req = 0; dma_req = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // The store attempted during reset must not have reached memory.
    cyc(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    // Starvation: the counter starts at 0 after reset, so the CPU wins cycles 1-4.
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'hA5A5A5A5, 0, 32'hDEADBEEF);
    // Cycle 5: a forced DMA write that stalls the CPU.
    cyc(1, 0, 32'h10, 32'h0, 1, 1, 32'h30, 32'hA5A5A5A5, 1, 32'h0);
    // Cycle 6: the CPU load sees the DMA write. A new DMA read waits again from 0.
    cyc(1, 0, 32'h30, 32'h0, 1, 0, 32'h10, 32'h0, 0, 32'hA5A5A5A5);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 32'h30, 32'h0, 1, 0, 32'h10, 32'h0, 0, 32'hA5A5A5A5);
    cyc(1, 0, 32'h30, 32'h0, 1, 0, 32'h10, 32'h0, 1, 32'hDEADBEEF);

    // Withdrawal: 3 contested cycles, 1 cycle with the DMA request dropped, then 4 more
    // contested cycles before the forced grant.
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 32'h50, 32'h11, 1, 0, 32'h20, 32'h0, 0, 32'h0);
    cyc(1, 1, 32'h50, 32'h22, 0, 0, 32'h20, 32'h0, 0, 32'h0);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 32'h50, 32'h0, 1, 0, 32'h20, 32'h0, 0, 32'h22);
    cyc(1, 0, 32'h50, 32'h0, 1, 0, 32'h20, 32'h0, 1, 32'h12345678);

    // Back-to-back DMA reads while the CPU is idle.
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 1, 32'hA5A5A5A5);
    cyc(0, 0, 32'h0, 32'h0, 1, 0, 32'h50, 32'h0, 1, 32'h22);
    idle();
    idle();

    chk("dma_return_drained", q_dma.size(), 32'd0);
    chk("ctl_drained",        q_ctl.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
